fetch_issue_ctrl: RTL
=====================

// Module: fetch_issue_ctrl
// PURPOSE
//   Sequencer for the instruction memory of the Tomasulo core. Drives the PC into
//   the registered-read instruction memory and buffers the returned words in a
//   small in-order instruction queue. Decodes the head opcode and issues it, by
//   valid/ready handshake, to the adder or multiplier reservation-station group.
//   Stops after PROG_LEN words and reports done.
// PARAMETERS
//   PC_W      5   PC / memory address width
//   INSTR_W   16  instruction width; [15:12] opcode, [11:8] rd, [7:4] rs1, [3:0] rs2
//   IQ_DEPTH  4   instruction-queue entries (power of 2, >=2)
//   PROG_LEN  6   number of words fetched per run (1..2**PC_W)
// PORTS
//   clock1         in   1        single clock, all state on posedge
//   rst_n          in   1        asynchronous, active-low reset
//   start          in   1        pulse; begins a run from PC 0 (IDLE/DONE only)
//   pc             out  PC_W     address to instruction memory, sampled every posedge
//   imem_rdata     in   INSTR_W  mem[pc sampled at previous posedge]
//   iss_instr      out  INSTR_W  head-of-queue instruction
//   iss_add_valid  out  1        head is ADD(0000)/SUB(0001)
//   iss_add_ready  in   1        adder RS has a free entry
//   iss_mul_valid  out  1        head is MUL(0010)/DIV(0011)
//   iss_mul_ready  in   1        multiplier RS has a free entry
//   issue_cnt      out  PC_W+1   instructions issued this run
//   busy           out  1        state is RUN or DRAIN
//   done           out  1        state is DONE
//   err            out  1        sticky: illegal opcode seen this run
// BEHAVIOUR
//   Reset (async, rst_n=0): state IDLE; pc=0, queue empty, pend=0; issue_cnt=0;
//     busy/done/err=0; iss_*_valid=0; iss_instr=0. Mid-run reset discards all
//     queued/pending words immediately.
//   FSM: IDLE -start-> RUN; RUN -(pc==PROG_LEN)-> DRAIN;
//     DRAIN -(no pend & queue empties this cycle)-> DONE; DONE -start-> RUN.
//     Entering RUN clears pc, issue_cnt, err. start in RUN/DRAIN is ignored.
//   Fetch: fetch_req = RUN & pc<PROG_LEN & (count+pend < IQ_DEPTH). A same-cycle pop
//     earns no credit. On fetch_req, pc increments at the edge and pend is set.
//     Otherwise pc holds and pend clears.
//   Return: latency 1. While pend=1, imem_rdata is pushed into the queue at the
//     closing edge. Pointers wrap modulo IQ_DEPTH; simultaneous push+pop keeps count.
//   Issue: combinational from head. Exactly one iss_*_valid high while the queue is
//     non-empty and the head is legal. Valid and iss_instr stay stable until ready.
//     The pop and issue_cnt++ occur on valid&ready. Strictly in order: a stalled
//     head blocks the other class.
//   Illegal opcode (01xx..11xx) at head: no valid asserted, popped in 1 cycle,
//     err<=1, not counted.
//   Empty queue: both valids 0, iss_instr holds last value.
// STRUCTURE
//   Shared package tomasulo_pkg: opcode localparams (OP_ADD=0, OP_SUB=1, OP_MUL=2,
//     OP_DIV=3), the instruction field slices, and the FSM state encoding.
//   One sub-module: iq_fifo (parameterised sync FIFO; push/pop/count/head outputs).
//   FSM, fetch credit and decode/issue logic live in this module.
// TESTING
//   Program used: 2123,0345,089A,27AB,3638,1B56 (hex), both readies held at 1.
//   T1 start at edge E0 -> pc 0..5 over cycles 1..6. First iss_mul_valid is in
//     cycle 3 with 2123. Issue order is mul,add,add,mul,mul,add. done=1 from
//     cycle 9, issue_cnt=6, err=0.
//   T2 iss_add_ready=0 from reset, mul ready=1 -> 2123 issues. Head 0345 holds
//     iss_add_valid with iss_instr stable. Queue reaches 4 (0345..3638), pc stalls
//     at 5. Releasing ready resumes and completes the run with issue_cnt=6.
//   T3 word 2 = 7000 -> dropped one cycle after reaching head, err=1 sticky,
//     issue_cnt=5, done still reached. The next start clears err.
//   T4 rst_n low during cycle 4 of T1 -> all outputs at reset values at once.
//     Re-run after release matches T1 exactly.
//   T5 start pulsed during RUN and DRAIN -> ignored (pc/issue_cnt unaffected).
//     start in DONE -> new run from pc 0.
//   T6 random ready toggling over 1000 runs -> issued sequence equals program
//     order, no valid drop before handshake, count never exceeds IQ_DEPTH.

Source files
------------

// File: rtl/tomasulo_pkg.sv
// Shared definitions for the Tomasulo front end: opcodes, instruction field
// positions, fetch/issue FSM states and the opcode-to-RS-group decode.
package tomasulo_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 8;
    localparam int RS1_MSB = 7;
    localparam int RS1_LSB = 4;
    localparam int RS2_MSB = 3;
    localparam int RS2_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        CLS_ADD = 2'd0,
        CLS_MUL = 2'd1,
        CLS_ILL = 2'd2
    } op_class_e;

    function automatic op_class_e op_class(input logic [3:0] opc);
        case (opc)
            OP_ADD, OP_SUB: op_class = CLS_ADD;
            OP_MUL, OP_DIV: op_class = CLS_MUL;
            default:        op_class = CLS_ILL;
        endcase
    endfunction

endpackage

// File: rtl/iq_fifo.sv
// In-order instruction queue: register-array FIFO with a combinational head
// so the issue logic can decode the oldest entry in the same cycle.
module iq_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/fetch_issue_ctrl.sv
// Fetch/issue sequencer: streams PROG_LEN words from a registered-read instruction
// memory through a small queue and issues them in order to the adder/multiplier RS.
module fetch_issue_ctrl
    import tomasulo_pkg::*;
#(
    parameter int PC_W     = 5,
    parameter int INSTR_W  = 16,
    parameter int IQ_DEPTH = 4,
    parameter int PROG_LEN = 6
) (
    input  logic               clock1,
    input  logic               rst_n,
    input  logic               start,
    output logic [PC_W-1:0]    pc,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] iss_instr,
    output logic               iss_add_valid,
    input  logic               iss_add_ready,
    output logic               iss_mul_valid,
    input  logic               iss_mul_ready,
    output logic [PC_W:0]      issue_cnt,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int              CNT_W    = $clog2(IQ_DEPTH) + 1;
    localparam logic [PC_W:0]   PROG_END = (PC_W + 1)'(PROG_LEN);
    localparam logic [CNT_W:0]  DEPTH_V  = (CNT_W + 1)'(IQ_DEPTH);

    state_e             state_q, state_d;
    logic [PC_W:0]      pc_q, pc_d;
    logic               pend_q, pend_d;
    logic [PC_W:0]      issue_cnt_q, issue_cnt_d;
    logic               err_q, err_d;
    logic [INSTR_W-1:0] last_instr_q;

    logic [INSTR_W-1:0] fifo_head;
    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_empty;
    logic               fifo_pop;
    op_class_e          head_cls;
    logic               drop_illegal;
    logic               issue_fire;
    logic               fetch_req;
    logic [CNT_W:0]     occupancy;

    iq_fifo #(
        .DEPTH (IQ_DEPTH),
        .WIDTH (INSTR_W)
    ) u_iq (
        .clk       (clock1),
        .rst_n     (rst_n),
        .push      (pend_q),
        .push_data (imem_rdata),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    assign head_cls      = op_class(fifo_head[OPC_MSB:OPC_LSB]);
    assign iss_add_valid = ~fifo_empty & (head_cls == CLS_ADD);
    assign iss_mul_valid = ~fifo_empty & (head_cls == CLS_MUL);
    assign drop_illegal  = ~fifo_empty & (head_cls == CLS_ILL);
    assign issue_fire    = (iss_add_valid & iss_add_ready) | (iss_mul_valid & iss_mul_ready);
    assign fifo_pop      = issue_fire | drop_illegal;

    // In-flight word counts against capacity; a pop in the same cycle earns no credit.
    assign occupancy = (CNT_W + 1)'(fifo_count) + (CNT_W + 1)'(pend_q);
    assign fetch_req = (state_q == ST_RUN) && (pc_q < PROG_END) && (occupancy < DEPTH_V);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pend_d      = fetch_req;
        issue_cnt_d = issue_cnt_q + (PC_W + 1)'(issue_fire);
        err_d       = err_q | drop_illegal;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d     = ST_RUN;
                    pc_d        = '0;
                    issue_cnt_d = '0;
                    err_d       = 1'b0;
                end
            end
            ST_RUN: begin
                if (pc_q == PROG_END) state_d = ST_DRAIN;
                else if (fetch_req)   pc_d    = pc_q + (PC_W + 1)'(1);
            end
            ST_DRAIN: begin
                if (!pend_q && (fifo_empty || (fifo_count == CNT_W'(1) && fifo_pop)))
                    state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            pc_q         <= '0;
            pend_q       <= 1'b0;
            issue_cnt_q  <= '0;
            err_q        <= 1'b0;
            last_instr_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pend_q      <= pend_d;
            issue_cnt_q <= issue_cnt_d;
            err_q       <= err_d;
            if (!fifo_empty) last_instr_q <= fifo_head;
        end
    end

    // An empty queue keeps presenting the most recent head.
    assign iss_instr = fifo_empty ? last_instr_q : fifo_head;
    assign pc        = pc_q[PC_W-1:0];
    assign issue_cnt = issue_cnt_q;
    assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done      = (state_q == ST_DONE);
    assign err       = err_q;

endmodule
